// File: rtl/rx_header_seeker.sv
// 64b/66b block-alignment search: slips the candidate header offset until LOCK_CNT good
// headers lock it, then drops lock after BAD_MAX bad headers in a WINDOW-check window.
// Optional: HEADER_SEEKER_GBOX_GATE_EN ignores strobes on the gearbox slip phase (gbox_cnt == 32).
module rx_header_seeker #(
   parameter int unsigned LOCK_CNT   = 32,
   parameter int unsigned BAD_MAX    = 16,
   parameter int unsigned WINDOW     = 64,
   parameter int unsigned MAX_OFFSET = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         buffer_dv,
   input  logic [193:0] gbox_buffer,
   input  logic [5:0]   gbox_cnt,
   output logic [6:0]   block_offset
);

   typedef enum logic [0:0] {StSearch, StLocked} state_e;

   localparam logic [5:0] GoodLast  = 6'(LOCK_CNT - 1);
   localparam logic [4:0] BadLast   = 5'(BAD_MAX - 1);
   localparam logic [6:0] WinLast   = 7'(WINDOW - 1);
   localparam logic [6:0] OffsetMax = 7'(MAX_OFFSET);

   state_e     state;
   logic [5:0] good_cnt;
   logic [6:0] win_cnt;
   logic [4:0] bad_cnt;

   logic       strobe;
   logic [7:0] lo_idx;
   logic [7:0] hi_idx;
   logic       hdr_ok;
   logic [6:0] slip_offset;

`ifdef HEADER_SEEKER_GBOX_GATE_EN
   assign strobe = buffer_dv && (gbox_cnt != 6'd32);
`else
   logic unused_gbox_cnt;
   assign unused_gbox_cnt = ^gbox_cnt;
   assign strobe = buffer_dv;
`endif

   // Header for offset k sits at bits {129+k, 128+k} of the live gearbox buffer.
   assign lo_idx      = {1'b0, block_offset} + 8'd128;
   assign hi_idx      = lo_idx + 8'd1;
   assign hdr_ok      = gbox_buffer[hi_idx] ^ gbox_buffer[lo_idx];
   assign slip_offset = (block_offset == OffsetMax) ? 7'd0 : block_offset + 7'd1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= StSearch;
         good_cnt     <= '0;
         win_cnt      <= '0;
         bad_cnt      <= '0;
         block_offset <= '0;
      end else if (strobe) begin
         unique case (state)
            StSearch: begin
               if (hdr_ok) begin
                  if (good_cnt == GoodLast) begin
                     state    <= StLocked;
                     good_cnt <= '0;
                     win_cnt  <= '0;
                     bad_cnt  <= '0;
                  end else begin
                     good_cnt <= good_cnt + 6'd1;
                  end
               end else begin
                  good_cnt     <= '0;
                  block_offset <= slip_offset;
               end
            end
            StLocked: begin
               // Loss of lock wins over a window rollover on the same check.
               if (!hdr_ok && (bad_cnt == BadLast)) begin
                  state        <= StSearch;
                  block_offset <= slip_offset;
                  good_cnt     <= '0;
                  win_cnt      <= '0;
                  bad_cnt      <= '0;
               end else if (win_cnt == WinLast) begin
                  win_cnt <= '0;
                  bad_cnt <= '0;
               end else begin
                  win_cnt <= win_cnt + 7'd1;
                  if (!hdr_ok) bad_cnt <= bad_cnt + 5'd1;
               end
            end
            default: state <= StSearch;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_header_seeker.sv
// Bench for rx_header_seeker: per-scenario tasks push the expected offset per strobe
// and compare it after the sampling edge.
module tb_rx_header_seeker;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         buffer_dv = 1'b0;
   logic [193:0] gbox_buffer = '0;
   logic [5:0]   gbox_cnt = 6'd0;
   logic [6:0]   block_offset;

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];
   logic [6:0] exp_v;

   rx_header_seeker dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .buffer_dv    (buffer_dv),
      .gbox_buffer  (gbox_buffer),
      .gbox_cnt     (gbox_cnt),
      .block_offset (block_offset)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [193:0] one_bit(input int pos);
      logic [193:0] b;
      b = '0;
      b[pos] = 1'b1;
      return b;
   endfunction

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic strobe(input logic [193:0] b, input logic dv);
      gbox_buffer = b;
      buffer_dv   = dv;
      @(posedge clk_i);
      #1;
      buffer_dv = 1'b0;
   endtask

   task automatic do_reset();
      rst_i     = 1'b1;
      buffer_dv = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic run_seq(input string name, input logic [193:0] b, input int n, input int start);
      for (int i = 0; i < n; i++) begin
         strobe(b, 1'b1);
         exp_v = exp_q.pop_front();
         checks++;
         if (block_offset !== exp_v) begin
            errors++;
            $display("FAIL %s strobe %0d: block_offset=%0d expected %0d", name, start + i,
                     block_offset, exp_v);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (block_offset !== 7'd0) begin
         errors++;
         $display("FAIL reset_release: block_offset=%0d expected 0", block_offset);
      end
      // Offsets 0..6 see "00"; offset 7 sees "10" from bit 136.
      for (int i = 1; i <= 10; i++) exp_q.push_back(7'(i < 7 ? i : 7));
      run_seq("reach_7", one_bit(136), 10, 1);
      #2;
      rst_i = 1'b1;
      #1;
      checks++;
      if (block_offset !== 7'd0) begin
         errors++;
         $display("FAIL async_reset: block_offset=%0d expected 0 before any edge", block_offset);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic test_lock_hold();
      do_reset();
      for (int i = 0; i < 32; i++) exp_q.push_back(7'd0);
      run_seq("lock_good", one_bit(129), 32, 1);
      for (int i = 0; i < 15; i++) exp_q.push_back(7'd0);
      run_seq("locked_15_bad", '0, 15, 1);
      // Sixteenth bad header in the window drops lock and slips.
      exp_q.push_back(7'd1);
      run_seq("locked_16th_bad", '0, 1, 16);
   endtask

   task automatic test_slip();
      do_reset();
      for (int i = 1; i <= 20; i++) exp_q.push_back(7'(i < 11 ? i : 11));
      run_seq("slip_to_11", one_bit(140), 20, 1);
      // Idle cycles with a bad header must change nothing.
      for (int i = 0; i < 4; i++) strobe('0, 1'b0);
      checks++;
      if (block_offset !== 7'd11) begin
         errors++;
         $display("FAIL idle_hold: block_offset=%0d expected 11", block_offset);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 1; i <= 140; i++) exp_q.push_back(7'(i % 65));
      run_seq("wrap", one_bit(127), 140, 1);
   endtask

   task automatic test_windows();
      do_reset();
      for (int i = 0; i < 32; i++) exp_q.push_back(7'd0);
      run_seq("win_lock", one_bit(129), 32, 1);
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 64; i++) exp_q.push_back(7'd0);
         run_seq("win_15_bad", '0, 15, 1);
         run_seq("win_good", one_bit(129), 49, 16);
      end
      // Third window: 48 good, then the 16th bad lands on the 64th check.
      for (int i = 0; i < 63; i++) exp_q.push_back(7'd0);
      run_seq("win3_good", one_bit(129), 48, 1);
      run_seq("win3_bad", '0, 15, 49);
      exp_q.push_back(7'd1);
      run_seq("win3_loss_on_last", '0, 1, 64);
   endtask

   task automatic test_back_to_back_relock();
      // After loss at offset 1, bit 130 gives "10" at offset 1: relock there.
      for (int i = 0; i < 32; i++) exp_q.push_back(7'd1);
      run_seq("relock", one_bit(130), 32, 1);
      for (int i = 0; i < 15; i++) exp_q.push_back(7'd1);
      run_seq("relock_hold", '0, 15, 1);
   endtask

`ifdef HEADER_SEEKER_GBOX_GATE_EN
   task automatic test_gbox_gate();
      do_reset();
      gbox_cnt = 6'd32;
      for (int i = 0; i < 5; i++) exp_q.push_back(7'd0);
      run_seq("gate_slip_phase", '0, 5, 1);
      gbox_cnt = 6'd5;
      for (int i = 1; i <= 3; i++) exp_q.push_back(7'(i));
      run_seq("gate_open", '0, 3, 1);
      gbox_cnt = 6'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_lock_hold();
      test_slip();
      test_wrap();
      test_windows();
      test_back_to_back_relock();
`ifdef HEADER_SEEKER_GBOX_GATE_EN
      test_gbox_gate();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
